dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, sets the word address width of the shared data RAM.
REQ-002 Parameter DATA_W, default 32, sets the data word width.
REQ-003 Parameter STARVE_LIMIT, default 4, sets the consecutive denied m1 cycles after which m1 takes priority (legal range 1..15).
REQ-004 Port clock, input, 1, is the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, is an asynchronous active-low reset: 0 resets immediately, 1 releases.
REQ-006 Port m0_req / m0_we, input, 1 each, carry the processor request and write-enable.
REQ-007 Port m0_addr, input, ADDR_W, and port m0_wdata, input, DATA_W, carry the processor address and write data.
REQ-008 Port m0_gnt, output, 1, and port m0_rvalid, output, 1, carry the processor grant and read-data valid.
REQ-009 Port m0_rdata, output, DATA_W, carries the processor read data.
REQ-010 Ports m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid and m1_rdata form the peripheral/loader port, identical to m0 in width and direction.
REQ-011 Ports ram_wEn (output, 1), ram_addr (output, ADDR_W) and ram_dataIn (output, DATA_W) drive the RAM.
REQ-012 Port ram_dataOut, input, DATA_W, carries RAM read data, valid one clock after the address is presented.
REQ-013 Port busy, output, 1, is high in any cycle where a grant is issued or a read response is pending.

Function
REQ-014 Arbitration SHALL be combinational within the cycle, with at most one of m0_gnt/m1_gnt high per cycle.
REQ-015 A requester SHALL hold req, we, addr and wdata stable until it samples its gnt high; the transfer completes in the gnt cycle.
REQ-016 If only one port requests, that port SHALL be granted the same cycle.
REQ-017 If both ports request, m0 SHALL win unless wait_cnt >= STARVE_LIMIT, in which case m1 SHALL win.
REQ-018 wait_cnt (4-bit, saturating at 15) SHALL increment on each cycle with m1_req=1 and m1_gnt=0, and SHALL clear on any cycle with m1_gnt=1 or m1_req=0.
REQ-019 During a grant, ram_addr, ram_dataIn and ram_wEn SHALL equal the granted port's addr, wdata and we.
REQ-020 With no grant, ram_wEn SHALL be 0, ram_addr SHALL be 0 and ram_dataIn SHALL be 0.
REQ-021 A granted read (we=0) SHALL raise that port's rvalid for exactly the following cycle; granted writes SHALL raise no rvalid.
REQ-022 The owner of the pending read SHALL be registered, so rvalid goes to the correct port even when a different port is granted in the response cycle.
REQ-023 m0_rdata and m1_rdata SHALL both equal ram_dataOut combinationally; only rvalid qualifies the data.
REQ-024 Back-to-back grants SHALL be supported every cycle: a new grant may be issued in the same cycle as the previous read's rvalid.

Reset
REQ-025 While reset=0: wait_cnt=0, the pending-read owner is cleared, m0_rvalid=m1_rvalid=0, and busy reflects only current grants.
REQ-026 Assertion of reset mid-read SHALL drop the pending rvalid; no rvalid may appear after reset release for a read granted before reset.
REQ-027 Grants SHALL be combinational, so no grant is issued while reset=0: gnt outputs are forced to 0 during reset.

Verification
REQ-028 m0 alone reads addr 0x010 preloaded with 0xDEADBEEF -> m0_gnt is high in cycle N, and m0_rvalid=1 with m0_rdata=0xDEADBEEF in cycle N+1, with m1_rvalid=0.
REQ-029 m0 writes 0x12345678 to 0x020, then m1 reads 0x020 -> m1_rdata=0x12345678 on m1_rvalid.
REQ-030 m0 and m1 request continuously with STARVE_LIMIT=4 -> m1_gnt is high in exactly 1 of every 5 cycles, after 4 m0 grants, and never 2 grants in one cycle.
REQ-031 m0 read in cycle N, then m1 write in cycle N+1 -> m0_rvalid=1 and m1_gnt=1 in N+1, ram_wEn=1 in N+1, and m1_rvalid stays 0.
REQ-032 reset driven to 0 in the cycle after an m1 read grant, then released -> m1_rvalid never asserts, wait_cnt=0, and all outputs are idle.
REQ-033 No requests from either port -> ram_wEn=0, ram_addr=0, busy=0, and wait_cnt remains 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of a single-port synchronous data RAM
// m0 (processor) has priority; m1 (peripheral/loader) takes over after STARVE_LIMIT denied cycles.
module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut,

    output logic              busy
);

    logic [3:0] wait_cnt;
    logic       pend_m0;
    logic       pend_m1;
    logic       starve;

    assign starve = (wait_cnt >= 4'(STARVE_LIMIT));

    // Grants are gated by reset so nothing reaches the RAM while the block is held in reset.
    assign m1_gnt = reset & m1_req & (~m0_req | starve);
    assign m0_gnt = reset & m0_req & ~m1_gnt;

    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = '0;
        ram_dataIn = '0;
        if (m0_gnt) begin
            ram_wEn    = m0_we;
            ram_addr   = m0_addr;
            ram_dataIn = m0_wdata;
        end else if (m1_gnt) begin
            ram_wEn    = m1_we;
            ram_addr   = m1_addr;
            ram_dataIn = m1_wdata;
        end
    end

    // Pending-read owner is tracked per port so a response never follows the current grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 4'd0;
            pend_m0  <= 1'b0;
            pend_m1  <= 1'b0;
        end else begin
            pend_m0 <= m0_gnt & ~m0_we;
            pend_m1 <= m1_gnt & ~m1_we;
            if (m1_req && !m1_gnt) begin
                if (wait_cnt != 4'hF) begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
            end else begin
                wait_cnt <= 4'd0;
            end
        end
    end

    assign m0_rvalid = pend_m0;
    assign m1_rvalid = pend_m1;
    assign m0_rdata  = ram_dataOut;
    assign m1_rdata  = ram_dataOut;
    assign busy      = m0_gnt | m1_gnt | pend_m0 | pend_m1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural reference model
module tb_dmem_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SL = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          ram_wEn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dataIn;
    logic [DW-1:0] ram_dataOut = '0;
    logic          busy;

    int tests = 0;
    int fails = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous RAM the arbiter drives: data appears one clock after the address.
    logic [DW-1:0] env_mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) env_mem[i] = '0;
        env_mem[12'h010] = 32'hDEADBEEF;
        forever begin
            @(posedge clock);
            ram_dataOut <= env_mem[ram_addr];
            if (ram_wEn) env_mem[ram_addr] = ram_dataIn;
        end
    end

    // Reference model: priority rule, starvation counter, one-cycle read response, word memory.
    logic [DW-1:0] ref_mem [int];
    int            m_wait = 0;
    int            m_pend = 0;
    logic [DW-1:0] m_pdata = '0;

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    initial begin
        bit e0, e1;
        ref_mem[32'h010] = 32'hDEADBEEF;
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("rst_m0_gnt", m0_gnt, 0);
                chk("rst_m1_gnt", m1_gnt, 0);
                chk("rst_m0_rvalid", m0_rvalid, 0);
                chk("rst_m1_rvalid", m1_rvalid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_ram_wEn", ram_wEn, 0);
                m_wait = 0;
                m_pend = 0;
            end else begin
                e1 = m1_req && (!m0_req || m_wait >= SL);
                e0 = m0_req && !e1;
                chk("m_m0_gnt", m0_gnt, e0);
                chk("m_m1_gnt", m1_gnt, e1);
                chk("m_m0_rvalid", m0_rvalid, m_pend == 1);
                chk("m_m1_rvalid", m1_rvalid, m_pend == 2);
                if (m_pend == 1) chk("m_m0_rdata", m0_rdata, m_pdata);
                if (m_pend == 2) chk("m_m1_rdata", m1_rdata, m_pdata);
                chk("m_ram_wEn", ram_wEn, e0 ? m0_we : e1 ? m1_we : 1'b0);
                chk("m_ram_addr", ram_addr, e0 ? m0_addr : e1 ? m1_addr : '0);
                chk("m_ram_dataIn", ram_dataIn, e0 ? m0_wdata : e1 ? m1_wdata : '0);
                chk("m_busy", busy, e0 || e1 || m_pend != 0);
                m_pend = 0;
                if (e0) begin
                    if (m0_we) ref_mem[int'(m0_addr)] = m0_wdata;
                    else begin m_pend = 1; m_pdata = ref_rd(int'(m0_addr)); end
                end
                if (e1) begin
                    if (m1_we) ref_mem[int'(m1_addr)] = m1_wdata;
                    else begin m_pend = 2; m_pdata = ref_rd(int'(m1_addr)); end
                end
                if (m1_req && !e1) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
                else m_wait = 0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        int n1;
        // Reset held with a live m0 request: no grant may leak out.
        drive(1, 0, 12'h010, '0, 0, 0, '0, '0);
        step();
        @(negedge clock);
        chk("rst_req_m0_gnt", m0_gnt, 0);
        chk("rst_wait_cnt", dut.wait_cnt, 0);
        step();
        idle();
        reset = 1'b1;

        // Idle cycles after release.
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clock);
            chk("idle_wEn", ram_wEn, 0);
            chk("idle_addr", ram_addr, 0);
            chk("idle_busy", busy, 0);
            chk("idle_wait_cnt", dut.wait_cnt, 0);
        end

        // m0 reads preloaded word.
        step(); drive(1, 0, 12'h010, '0, 0, 0, '0, '0);
        @(negedge clock);
        chk("rd_m0_gnt", m0_gnt, 1);
        step(); idle();
        @(negedge clock);
        chk("rd_m0_rvalid", m0_rvalid, 1);
        chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rd_m1_rvalid", m1_rvalid, 0);
        step();

        // m0 writes, m1 reads it back.
        step(); drive(1, 1, 12'h020, 32'h12345678, 0, 0, '0, '0);
        @(negedge clock);
        chk("wr_m0_gnt", m0_gnt, 1);
        chk("wr_ram_wEn", ram_wEn, 1);
        step(); drive(0, 0, '0, '0, 1, 0, 12'h020, '0);
        @(negedge clock);
        chk("wr_m0_rvalid", m0_rvalid, 0);
        chk("rb_m1_gnt", m1_gnt, 1);
        step(); idle();
        @(negedge clock);
        chk("rb_m1_rvalid", m1_rvalid, 1);
        chk("rb_m1_rdata", m1_rdata, 32'h12345678);
        step();

        // m0 read followed by m1 write in the response cycle.
        step(); drive(1, 0, 12'h020, '0, 0, 0, '0, '0);
        @(negedge clock);
        step(); drive(0, 0, '0, '0, 1, 1, 12'h030, 32'hA5A5A5A5);
        @(negedge clock);
        chk("b2b_m0_rvalid", m0_rvalid, 1);
        chk("b2b_m0_rdata", m0_rdata, 32'h12345678);
        chk("b2b_m1_gnt", m1_gnt, 1);
        chk("b2b_ram_wEn", ram_wEn, 1);
        chk("b2b_m1_rvalid", m1_rvalid, 0);
        step(); idle();
        @(negedge clock);
        chk("b2b_m1_rvalid_after", m1_rvalid, 0);
        step();

        // Continuous contention: m1 wins every fifth cycle.
        n1 = 0;
        for (int i = 0; i < 20; i++) begin
            step(); drive(1, 0, 12'h040, '0, 1, 0, 12'h010, '0);
            @(negedge clock);
            chk("starve_one_gnt", m0_gnt & m1_gnt, 0);
            chk("starve_m1_slot", m1_gnt, (i % 5) == 4);
            if (m1_gnt) n1++;
        end
        chk("starve_m1_count", n1, 4);
        step(); idle();
        @(negedge clock);
        step();

        // Reset asserted in the response cycle of an m1 read.
        step(); drive(0, 0, '0, '0, 1, 0, 12'h010, '0);
        @(negedge clock);
        chk("rr_m1_gnt", m1_gnt, 1);
        step(); idle(); reset = 1'b0;
        @(negedge clock);
        chk("rr_m1_rvalid_rst", m1_rvalid, 0);
        step(); reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rr_m1_rvalid_post", m1_rvalid, 0);
            chk("rr_wait_cnt", dut.wait_cnt, 0);
            chk("rr_busy", busy, 0);
            chk("rr_ram_addr", ram_addr, 0);
            step();
        end

        // m1 denied twice then withdraws: counter must clear.
        drive(1, 0, 12'h050, '0, 1, 0, 12'h060, '0);
        step();
        step(); drive(1, 0, 12'h050, '0, 0, 0, '0, '0);
        @(negedge clock);
        chk("wd_wait_cnt", dut.wait_cnt, 2);
        step(); idle();
        @(negedge clock);
        chk("wd_wait_clr", dut.wait_cnt, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule
